pulse_meter: RTL and testbench

PULSE_METER -- requirements
Module: pulse_meter

---
 rtl/pulse_meter.sv | 112 +++++++++++
 tb/tb_pulse_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Pulse-width meter: measures runs of in==1 and hands widths to a
// consumer over a dav_/rfd four-phase handshake, one-deep buffered.
module pulse_meter (
  input  logic       clock,
  input  logic       reset_,
  input  logic       in,
  input  logic       rfd,
  output logic       dav_,
  output logic [7:0] data,
  output logic [7:0] drops
);

  typedef enum logic {
    M_LOW,
    M_HIGH
  } m_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_OFFER,
    P_DONE
  } p_state_t;

  m_state_t   m_state;
  m_state_t   m_next;
  p_state_t   p_state;
  p_state_t   p_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] pend;
  logic       pv;
  logic       push;
  logic       pop;

  always_comb begin
    m_next   = m_state;
    cnt_next = cnt;
    push     = 1'b0;
    unique case (m_state)
      M_LOW: begin
        cnt_next = 8'd0;
        if (in) begin
          cnt_next = 8'd1;
          m_next   = M_HIGH;
        end
      end
      M_HIGH: begin
        if (in) begin
          if (cnt != 8'hff)
            cnt_next = cnt + 8'd1;
        end else begin
          push     = 1'b1;
          cnt_next = 8'd0;
          m_next   = M_LOW;
        end
      end
    endcase
  end

  always_comb begin
    p_next = p_state;
    pop    = 1'b0;
    unique case (p_state)
      P_IDLE: begin
        if (pv && rfd) begin
          pop    = 1'b1;
          p_next = P_OFFER;
        end
      end
      P_OFFER: begin
        if (!rfd)
          p_next = P_DONE;
      end
      P_DONE: begin
        if (rfd)
          p_next = P_IDLE;
      end
      default: p_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      m_state <= M_LOW;
      p_state <= P_IDLE;
      cnt     <= 8'd0;
      pend    <= 8'd0;
      pv      <= 1'b0;
      dav_    <= 1'b1;
      data    <= 8'd0;
      drops   <= 8'd0;
    end else begin
      m_state <= m_next;
      p_state <= p_next;
      cnt     <= cnt_next;
      dav_    <= (p_next != P_OFFER);
      if (pop)
        data <= pend;
      // A same-edge pop frees the slot, so the new result still fits.
      if (push && pv && !pop) begin
        if (drops != 8'hff)
          drops <= drops + 8'd1;
      end else if (push) begin
        pend <= cnt;
        pv   <= 1'b1;
      end else if (pop) begin
        pv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pulse_meter;

  logic       clock;
  logic       reset_;
  logic       in;
  logic       rfd;
  logic       dav_;
  logic [7:0] data;
  logic [7:0] drops;

  int checks   = 0;
  int failures = 0;

  pulse_meter dut (
    .clock  (clock),
    .reset_ (reset_),
    .in     (in),
    .rfd    (rfd),
    .dav_   (dav_),
    .data   (data),
    .drops  (drops)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: run length, one-deep pending queue, consumer phase.
  int m_run;
  int m_q[$];
  bit m_off;
  bit m_done;
  int m_drops;
  int m_data;
  int m_dav;

  task automatic model(input logic r, input logic i, input logic f);
    bit do_pop;
    bit do_push;
    int res;
    if (r) begin
      m_run = 0; m_q.delete(); m_off = 0; m_done = 0;
      m_drops = 0; m_data = 0; m_dav = 1;
      return;
    end
    do_push = (m_run > 0) && !i;
    res     = m_run;
    do_pop  = !m_off && !m_done && (m_q.size() > 0) && f;
    if (do_pop) begin
      m_data = m_q.pop_front();
      m_dav  = 0;
      m_off  = 1;
    end else if (m_off && !f) begin
      m_off  = 0;
      m_done = 1;
      m_dav  = 1;
    end else if (m_done && f) begin
      m_done = 0;
    end
    if (do_push) begin
      if (m_q.size() == 0) m_q.push_back(res);
      else if (m_drops < 255) m_drops++;
    end
    if (i) m_run = (m_run < 255) ? m_run + 1 : 255;
    else m_run = 0;
  endtask

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endfunction

  task automatic step(input logic r, input logic i, input logic f);
    logic       pd;
    logic [7:0] pdata;
    reset_ = r; in = i; rfd = f;
    pd    = dav_;
    pdata = data;
    @(posedge clock);
    @(negedge clock);
    model(r, i, f);
    chk("model_dav", int'(dav_), m_dav);
    chk("model_data", int'(data), m_data);
    chk("model_drops", int'(drops), m_drops);
    if (!r && pd === 1'b0 && dav_ === 1'b0) begin
      checks++;
      if (data !== pdata) begin
        failures++;
        $display("FAIL data_stable got=%0d exp=%0d", data, pdata);
      end
    end
    if (!r && pd === 1'b1 && dav_ === 1'b0) begin
      checks++;
      if (!f) begin
        failures++;
        $display("FAIL dav_fell_rfd0 got=rfd%0d exp=rfd1", f);
      end
    end
  endtask

  task automatic pulse(input int n, input logic f);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, f);
  endtask

  typedef struct {
    logic r;
    logic i;
    logic f;
    int   dav;
    int   dat;
    int   drp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    reset_ = 1'b1; in = 1'b0; rfd = 1'b1;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 0, 5, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1, 5, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1, 5, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1, 5, 0};
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].r, tbl[k].i, tbl[k].f);
      chk($sformatf("tbl%0d_dav", k), int'(dav_), tbl[k].dav);
      chk($sformatf("tbl%0d_data", k), int'(data), tbl[k].dat);
      chk($sformatf("tbl%0d_drops", k), int'(drops), tbl[k].drp);
    end
    // single-edge pulse yields 1
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("single_data", int'(data), 1);
    chk("single_dav", int'(dav_), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // saturation at 255
    pulse(300, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_data", int'(data), 255);
    chk("sat_drops", int'(drops), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // consumer stalls with rfd=1: 3 offered, 4 pending, 7 dropped
    step(1'b1, 1'b0, 1'b1);
    pulse(3, 1'b1); step(1'b0, 1'b0, 1'b1);
    pulse(4, 1'b1); step(1'b0, 1'b0, 1'b1);
    pulse(7, 1'b1); step(1'b0, 1'b0, 1'b1);
    chk("stall_dav", int'(dav_), 0);
    chk("stall_data", int'(data), 3);
    chk("stall_drops", int'(drops), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("stall_done_dav", int'(dav_), 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("stall_next_dav", int'(dav_), 0);
    chk("stall_next_data", int'(data), 4);
    chk("stall_next_drops", int'(drops), 1);

    // push and pop on the same edge
    step(1'b1, 1'b0, 1'b1);
    pulse(2, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    pulse(3, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("same_edge_data", int'(data), 3);
    chk("same_edge_dav", int'(dav_), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("same_edge_next_data", int'(data), 2);
    chk("same_edge_drops", int'(drops), 0);

    // reset while offering with a result pending
    pulse(6, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    pulse(2, 1'b1); step(1'b0, 1'b0, 1'b1);
    pulse(2, 1'b1); step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_dav", int'(dav_), 1);
    chk("rst_data", int'(data), 0);
    chk("rst_drops", int'(drops), 0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("rst_no_stale", int'(dav_), 1);
    end

    // pulse already high across reset release
    step(1'b1, 1'b1, 1'b1);
    pulse(2, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rel_data", int'(data), 2);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic r;
      logic i;
      logic f;
      r = ($urandom_range(0, 499) == 0);
      i = ($urandom_range(0, 3) != 0) ? in : ~in;
      f = ($urandom_range(0, 4) != 0) ? rfd : ~rfd;
      step(r, i, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
